// File: rtl/lw_sha_pkg.sv
// ------------------------------------------------------------------
// lw_sha_pkg: shared types and constants for the SHA-224/256 padder.
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

package lw_sha_pkg;

  localparam int                WORD_W       = 32;
  localparam logic [7:0]        PAD_BYTE     = 8'h80;
  localparam logic [WORD_W-1:0] MARK_WORD    = {PAD_BYTE, 24'h000000};
  // Last block index that may carry a zero word before the length pair
  localparam logic [3:0]        LAST_ZERO_IDX = 4'd13;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DATA      = 3'd1,
    ST_MARK      = 3'd2,
    ST_ZERO      = 3'd3,
    ST_LEN_HI    = 3'd4,
    ST_LEN_LO    = 3'd5,
    ST_WAIT_DONE = 3'd6
  } state_e;

endpackage

`default_nettype wire

// File: rtl/lw_sha_pad_word.sv
// ------------------------------------------------------------------
// lw_sha_pad_word: masks the unused tail bytes of a final word and inserts
// the 0x80 marker after the last valid byte.  Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module lw_sha_pad_word
  import lw_sha_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [2:0]        k_i,
  output logic [WORD_W-1:0] word_o
);

  always_comb begin
    word_o = word_i;
    case (k_i)
      3'd0:    word_o = MARK_WORD;
      3'd1:    word_o = {word_i[31:24], PAD_BYTE, 16'h0000};
      3'd2:    word_o = {word_i[31:16], PAD_BYTE, 8'h00};
      3'd3:    word_o = {word_i[31:8],  PAD_BYTE};
      default: word_o = word_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lw_sha_padder.sv
// ------------------------------------------------------------------
// lw_sha_padder: SHA-224/256 message padder feeding a word-stream hash core.
// Optional abort ports: define LW_SHA_PAD_ABORT_EN.  Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module lw_sha_padder
  import lw_sha_pkg::*;
(
  input  logic              clk_i,
  input  logic              aresetn_i,
  input  logic              opcode_i,
  input  logic              msg_valid_i,
  output logic              msg_ready_o,
  input  logic [WORD_W-1:0] msg_data_i,
  input  logic              msg_last_i,
  input  logic [2:0]        msg_bytes_i,
  output logic              start_o,
  output logic              data_valid_o,
  output logic              last_o,
  output logic [WORD_W-1:0] data_o,
  output logic              opcode_o,
  input  logic              core_ready_i,
  input  logic              word_ready_i,
  input  logic              done_i
`ifdef LW_SHA_PAD_ABORT_EN
  ,
  input  logic              abort_i,
  output logic              abort_o
`endif
);

  state_e            state_q, state_d;
  logic              hold_vld_q, hold_vld_d;
  logic [WORD_W-1:0] hold_data_q, hold_data_d;
  logic              hold_first_q, hold_first_d;
  logic              hold_fin_q, hold_fin_d;
  logic              hold_k4_q, hold_k4_d;
  logic              got_last_q, got_last_d;
  logic [63:0]       len_q, len_d;
  logic [3:0]        idx_q, idx_d;
  logic              opcode_q, opcode_d;

  logic              clr;
  logic              core_xfer;
  logic              up_xfer;
  logic [2:0]        k;
  logic [WORD_W-1:0] padded;
  logic              unused_core_ready;

  assign unused_core_ready = core_ready_i;

`ifdef LW_SHA_PAD_ABORT_EN
  assign clr     = !aresetn_i || abort_i;
  assign abort_o = abort_i;
`else
  assign clr     = !aresetn_i;
`endif

  assign k         = msg_last_i ? msg_bytes_i : 3'd4;
  assign core_xfer = data_valid_o && word_ready_i;
  assign up_xfer   = msg_valid_i && msg_ready_o;

  assign msg_ready_o = !clr && ((state_q == ST_IDLE) || (state_q == ST_DATA)) &&
                       (!hold_vld_q || core_xfer) && !got_last_q;
  assign start_o     = data_valid_o && hold_first_q && (state_q == ST_DATA);
  assign opcode_o    = opcode_q;

  lw_sha_pad_word u_pad (
    .word_i (msg_data_i),
    .k_i    (k),
    .word_o (padded)
  );

  always_comb begin
    data_valid_o = 1'b0;
    data_o       = '0;
    last_o       = 1'b0;
    case (state_q)
      ST_DATA: begin
        data_valid_o = hold_vld_q;
        data_o       = hold_data_q;
      end
      ST_MARK: begin
        data_valid_o = 1'b1;
        data_o       = MARK_WORD;
      end
      ST_ZERO: data_valid_o = 1'b1;
      ST_LEN_HI: begin
        data_valid_o = 1'b1;
        data_o       = len_q[63:32];
        last_o       = 1'b1;
      end
      ST_LEN_LO: begin
        data_valid_o = 1'b1;
        data_o       = len_q[31:0];
        last_o       = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    hold_vld_d   = hold_vld_q;
    hold_data_d  = hold_data_q;
    hold_first_d = hold_first_q;
    hold_fin_d   = hold_fin_q;
    hold_k4_d    = hold_k4_q;
    got_last_d   = got_last_q;
    len_d        = len_q;
    idx_d        = idx_q;
    opcode_d     = opcode_q;

    if (core_xfer) begin
      idx_d = idx_q + 4'd1;
      case (state_q)
        ST_DATA: begin
          hold_vld_d   = 1'b0;
          hold_first_d = 1'b0;
          // A final word with k<4 already carries the marker at this index
          if (hold_fin_q) begin
            if (hold_k4_q)                   state_d = ST_MARK;
            else if (idx_q == LAST_ZERO_IDX) state_d = ST_LEN_HI;
            else                             state_d = ST_ZERO;
          end
        end
        ST_MARK:   state_d = (idx_q == LAST_ZERO_IDX) ? ST_LEN_HI : ST_ZERO;
        ST_ZERO:   if (idx_q == LAST_ZERO_IDX) state_d = ST_LEN_HI;
        ST_LEN_HI: state_d = ST_LEN_LO;
        ST_LEN_LO: state_d = ST_WAIT_DONE;
        default: ;
      endcase
    end

    // Same-cycle reload after a core transfer keeps the stream bubble-free
    if (up_xfer) begin
      hold_vld_d   = 1'b1;
      hold_data_d  = padded;
      hold_first_d = (state_q == ST_IDLE);
      hold_fin_d   = msg_last_i;
      hold_k4_d    = (msg_bytes_i == 3'd4);
      got_last_d   = msg_last_i;
      len_d        = len_q + {58'd0, k, 3'd0};
      if (state_q == ST_IDLE) begin
        state_d  = ST_DATA;
        opcode_d = opcode_i;
      end
    end

    if ((state_q == ST_WAIT_DONE) && done_i) begin
      state_d    = ST_IDLE;
      idx_d      = '0;
      len_d      = '0;
      got_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr) begin
      state_q      <= ST_IDLE;
      hold_vld_q   <= 1'b0;
      hold_data_q  <= '0;
      hold_first_q <= 1'b0;
      hold_fin_q   <= 1'b0;
      hold_k4_q    <= 1'b0;
      got_last_q   <= 1'b0;
      len_q        <= '0;
      idx_q        <= '0;
      opcode_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_vld_q   <= hold_vld_d;
      hold_data_q  <= hold_data_d;
      hold_first_q <= hold_first_d;
      hold_fin_q   <= hold_fin_d;
      hold_k4_q    <= hold_k4_d;
      got_last_q   <= got_last_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      opcode_q     <= opcode_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/lw_sha_padder.md
LW_SHA_PADDER -- requirements
Module: lw_sha_padder

Interface
REQ-001 SHALL have exactly one clock, clk_i, and a synchronous active-low reset, aresetn_i, sampled only on the rising edge of clk_i.
REQ-002 clk_i  in  1  system clock.
REQ-003 aresetn_i  in  1  synchronous active-low reset.
REQ-004 opcode_i  in  1  0=SHA-256, 1=SHA-224; sampled with the first message word.
REQ-005 msg_valid_i / msg_ready_o  in/out  1/1  upstream word handshake; a transfer occurs when both are 1.
REQ-006 msg_data_i  in  32  message word, big-endian: byte 0 in [31:24].
REQ-007 msg_last_i  in  1  current word is the final word of the message.
REQ-008 msg_bytes_i  in  3  valid bytes in the final word (1..4); 0 is legal only with msg_last_i and means an empty message (msg_data_i ignored); ignored when msg_last_i=0.
REQ-009 start_o, data_valid_o, last_o, data_o[31:0], opcode_o  out  core word-stream controls and data.
REQ-010 core_ready_i  in  1  core idle; word_ready_i  in  1  core consumes data_o this cycle; done_i  in  1  core hash-complete pulse.

Function
REQ-011 A word transfer to the core SHALL occur when data_valid_o=1 and word_ready_i=1; data_o, last_o and start_o SHALL be held stable until that transfer.
REQ-012 FSM states: IDLE, DATA, MARK, ZERO, LEN_HI, LEN_LO, WAIT_DONE.
- IDLE: first msg transfer -> DATA.
- DATA: after the final data word is emitted -> MARK if msg_bytes=4, otherwise -> ZERO or LEN_HI.
- MARK/ZERO/LEN_HI/LEN_LO: advance on each core transfer.
- LEN_LO: transfer -> WAIT_DONE.
- WAIT_DONE: done_i -> IDLE.
REQ-013 The block SHALL contain a one-word holding register; msg_ready_o = (state is IDLE or DATA) and (register empty or a core transfer occurs this cycle) and no final word has yet been accepted.
REQ-014 start_o SHALL equal data_valid_o while the first word of a message is untransferred, and 0 otherwise.
REQ-015 A final word with k<4 bytes SHALL be emitted with bytes k..3 replaced by 0x80 followed by zeros.
REQ-016 When k=4, a separate marker word 0x80000000 SHALL follow (MARK state).
REQ-017 For the empty message (k=0), the first emitted word SHALL be 0x80000000, with start_o=1.
REQ-018 A 4-bit block word index SHALL wrap 15->0. Let p be the index of the marker word:
- if p<=13: zero words fill indices up to 13, then LEN_HI at index 14 and LEN_LO at index 15;
- if p>=14: zero words fill through index 15, a further block of zero words fills indices 0..13, then LEN_HI/LEN_LO.
REQ-019 Length SHALL be a 64-bit bit counter advanced by 8*bytes per accepted word, modulo 2^64. LEN_HI carries bits [63:32] and LEN_LO carries bits [31:0].
REQ-020 last_o SHALL be 1 exactly on the LEN_HI and LEN_LO words.
REQ-021 opcode_o SHALL be latched from opcode_i on the first message transfer and held until return to IDLE.
REQ-022 A core transfer and an upstream transfer in the same cycle SHALL both take effect: the register is reloaded with no bubble.
REQ-023 Latency: the first word is presented on data_o one cycle after it is accepted upstream.

Reset
REQ-024 On aresetn_i=0 at a clock edge, including mid-message, the block SHALL:
- enter IDLE;
- clear the holding register, counter, index and opcode_o;
- drive start_o, data_valid_o, last_o, msg_ready_o and data_o to 0.
REQ-025 msg_ready_o SHALL rise in the first cycle after reset is released.

Configuration
REQ-026 Macro LW_SHA_PAD_ABORT_EN. When defined, ports abort_i (in, 1) and abort_o (out, 1) SHALL exist, with behaviour:
- abort_o=abort_i, combinational;
- abort_i=1 forces IDLE on the next edge with the same clearing as reset.
When the macro is undefined, both ports SHALL be absent.

Structure
REQ-027 The state enum, the pad constant 0x80, and the word width 32 SHALL reside in lw_sha_pkg.
REQ-028 One combinational sub-module, lw_sha_pad_word, SHALL perform byte masking and marker insertion (inputs word and k; output padded word).

Verification
REQ-029 "abc" (one word, k=3, opcode 0) -> 16 words: 0x61626380, 0 x14, 0x00000018; start_o on word0; last_o on words 14 and 15.
REQ-030 55-byte message -> one block; word13=0x80 in bits [7:0]; word15=0x000001B8.
REQ-031 56-byte message -> two blocks: block1 word14=0x80000000, word15=0; block2 words0..14=0, word15=0x000001C0.
REQ-032 Empty message -> 0x80000000, 14 zero words, 0x00000000 with start_o and last_o as specified.
REQ-033 word_ready_i held low for 48 cycles between blocks (random stalls) -> data_o stable, no word lost or duplicated, msg_ready_o low while the register is full.
REQ-034 Reset asserted during word 7, then "abc" sent -> output identical to REQ-029; with LW_SHA_PAD_ABORT_EN, the same holds for abort_i asserted during word 7.
